// File: rtl/cu_fsm_ec2.sv
// cu_fsm_ec2: accumulator CPU control FSM with memory wait/timeout; CU_ILLEGAL_TRAP_EN traps opcodes >= 8
module cu_fsm_ec2 #(
  parameter int OPW      = 3,
  parameter int WAIT_MAX = 15,
  parameter int CW       = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] ir,
  input  logic           Aeq0,
  input  logic           Apos,
  input  logic           mem_ready,
  output logic           IRload,
  output logic           PCload,
  output logic           JMPmux,
  output logic           Meminst,
  output logic           MemWr,
  output logic [1:0]     Asel,
  output logic           Sub,
  output logic           Aload,
  output logic           Halt,
  output logic           mem_err,
`ifdef CU_ILLEGAL_TRAP_EN
  output logic           trap_o,
`endif
  output logic [2:0]     state_o
);
`ifdef CU_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {START = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, HALT = 3'd4, TRAP = 3'd5} state_t;
`else
  typedef enum logic [2:0] {START = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, HALT = 3'd4} state_t;
`endif
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          illegal, timeout;
  assign illegal = (ir >> 3) != '0;
  assign timeout = (WAIT_MAX != 0) && (cnt_q == CW'(WAIT_MAX));
  assign state_o = reset ? 3'd0 : state_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= START;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Asel    = 2'b00;
    Sub     = 1'b0;
    Aload   = 1'b0;
    Halt    = 1'b0;
    mem_err = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    trap_o  = 1'b0;
`endif
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        IRload  = 1'b1;
        PCload  = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        op_d    = ir[1:0];
        cnt_d   = '0;
        state_d = FETCH;
        if (illegal) begin
`ifdef CU_ILLEGAL_TRAP_EN
          state_d = TRAP;
`endif
        end else begin
          case (ir[2:0])
            3'b100: begin
              Asel  = 2'b01;
              Aload = 1'b1;
            end
            3'b101: {PCload, JMPmux} = {2{Aeq0}};
            3'b110: {PCload, JMPmux} = {2{Apos}};
            3'b111: state_d = HALT;
            default: state_d = EXEC;
          endcase
        end
      end
      EXEC: begin
        Meminst = 1'b1;
        if (mem_ready) begin
          MemWr   = op_q == 2'b01;
          Aload   = op_q != 2'b01;
          Asel    = op_q == 2'b00 ? 2'b10 : 2'b00;
          Sub     = op_q == 2'b11;
          cnt_d   = '0;
          state_d = FETCH;
        end else if (timeout) begin
          mem_err = 1'b1;
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HALT: Halt = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
      TRAP: begin
        Halt   = 1'b1;
        trap_o = 1'b1;
      end
`endif
      default: state_d = START;
    endcase
    // outputs drop the moment reset is seen, before the state register follows
    if (reset) begin
      {IRload, PCload, JMPmux, Meminst, MemWr, Asel, Sub, Aload, Halt, mem_err} = '0;
`ifdef CU_ILLEGAL_TRAP_EN
      trap_o = 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_cu_fsm_ec2.sv
// tb_cu_fsm_ec2: directed scoreboard bench for cu_fsm_ec2 built with OPW=4
module tb_cu_fsm_ec2;
  localparam logic [15:0] IRL = 16'h8000, PCL = 16'h4000, JMP = 16'h2000, MI = 16'h1000;
  localparam logic [15:0] MW = 16'h0800, AMEM = 16'h0400, AIN = 16'h0200, SUB = 16'h0100;
  localparam logic [15:0] AL = 16'h0080, HLT = 16'h0040, ME = 16'h0020, TR = 16'h0010;
  localparam logic [15:0] S_FE = 16'd1, S_DE = 16'd2, S_EX = 16'd3, S_HA = 16'd4, S_TR = 16'd5;
  localparam logic [15:0] FETCH = IRL | PCL | S_FE;
  logic clk = 1'b0, reset = 1'b1, Aeq0 = 1'b0, Apos = 1'b0, mem_ready = 1'b0;
  logic [3:0] ir = 4'd0;
  logic IRload, PCload, JMPmux, Meminst, MemWr, Sub, Aload, Halt, mem_err, trap_w;
  logic [1:0] Asel;
  logic [2:0] state_o;
  logic [15:0] sb[$];
  string tags[$];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  cu_fsm_ec2 #(.OPW(4), .WAIT_MAX(15), .CW(4)) dut (
    .clk(clk), .reset(reset), .ir(ir), .Aeq0(Aeq0), .Apos(Apos), .mem_ready(mem_ready),
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst), .MemWr(MemWr),
    .Asel(Asel), .Sub(Sub), .Aload(Aload), .Halt(Halt), .mem_err(mem_err),
`ifdef CU_ILLEGAL_TRAP_EN
    .trap_o(trap_w),
`endif
    .state_o(state_o)
  );
`ifndef CU_ILLEGAL_TRAP_EN
  assign trap_w = 1'b0;
`endif
  task automatic cyc(input logic r, input logic [3:0] op, input logic z, input logic p,
                     input logic rdy, input logic [15:0] exp, input string tag);
    logic [15:0] obs, e;
    string t;
    reset = r; ir = op; Aeq0 = z; Apos = p; mem_ready = rdy;
    sb.push_back(exp);
    tags.push_back(tag);
    @(negedge clk);
    obs = {IRload, PCload, JMPmux, Meminst, MemWr, Asel, Sub, Aload, Halt, mem_err, trap_w, 1'b0, state_o};
    e = sb.pop_front();
    t = tags.pop_front();
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic mem_op(input logic [3:0] op, input int waits, input logic [15:0] done, input string tag);
    cyc(0, op, 0, 0, 0, FETCH, {tag, "_fetch"});
    cyc(0, op, 0, 0, 0, S_DE, {tag, "_decode"});
    for (int i = 0; i < waits; i++) cyc(0, 4'd9, 1, 1, 0, MI | S_EX, {tag, "_wait"});
    cyc(0, 4'd9, 1, 1, 1, done, {tag, "_done"});
  endtask
  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) cyc(1, 4'd4, 1, 1, 1, 16'h0, "reset_zero");
    cyc(0, 4'd4, 0, 0, 0, 16'h0, "start");
    cyc(0, 4'd4, 0, 0, 0, FETCH, "in_fetch");
    cyc(0, 4'd4, 0, 0, 0, AIN | AL | S_DE, "in_decode");
    mem_op(4'd0, 3, MI | AMEM | AL | S_EX, "load");
    mem_op(4'd2, 0, MI | AL | S_EX, "add");
    mem_op(4'd3, 0, MI | SUB | AL | S_EX, "sub");
    mem_op(4'd1, 0, MI | MW | S_EX, "store");
    cyc(0, 4'd1, 0, 0, 0, FETCH, "to_fetch");
    cyc(0, 4'd1, 0, 0, 0, S_DE, "store_to_decode");
    for (int i = 0; i < 15; i++) cyc(0, 4'd0, 0, 0, 0, MI | S_EX, "store_wait");
    cyc(0, 4'd0, 0, 0, 0, MI | ME | S_EX, "timeout");
    mem_op(4'd0, 15, MI | AMEM | AL | S_EX, "ready_wins");
    cyc(0, 4'd5, 1, 0, 0, FETCH, "jz_fetch");
    cyc(0, 4'd5, 1, 0, 0, PCL | JMP | S_DE, "jz_taken");
    cyc(0, 4'd5, 0, 1, 0, FETCH, "jz_fetch2");
    cyc(0, 4'd5, 0, 1, 0, S_DE, "jz_not_taken");
    cyc(0, 4'd6, 0, 0, 0, FETCH, "jpos_fetch");
    cyc(0, 4'd6, 0, 0, 0, S_DE, "jpos_not_taken");
    cyc(0, 4'd6, 0, 1, 0, FETCH, "jpos_fetch2");
    cyc(0, 4'd6, 0, 1, 0, PCL | JMP | S_DE, "jpos_taken");
    cyc(0, 4'd1, 0, 0, 0, FETCH, "abort_fetch");
    cyc(0, 4'd1, 0, 0, 0, S_DE, "abort_decode");
    cyc(0, 4'd1, 0, 0, 0, MI | S_EX, "abort_wait");
    cyc(1, 4'd1, 0, 0, 1, 16'h0, "abort_reset");
    cyc(0, 4'd1, 0, 0, 1, 16'h0, "abort_start");
    cyc(0, 4'd10, 1, 1, 1, FETCH, "illegal_fetch");
    cyc(0, 4'd10, 1, 1, 1, S_DE, "illegal_decode");
`ifdef CU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc(0, 4'd0, 0, 0, 1, HLT | TR | S_TR, "trap_hold");
    cyc(1, 4'd0, 0, 0, 0, 16'h0, "trap_reset");
    cyc(0, 4'd0, 0, 0, 0, 16'h0, "trap_start");
`endif
    cyc(0, 4'd7, 0, 0, 0, FETCH, "halt_fetch");
    cyc(0, 4'd7, 0, 0, 0, S_DE, "halt_decode");
    for (int i = 0; i < 20; i++) cyc(0, 4'(i), i[0], i[1], i[2], HLT | S_HA, "halt_hold");
    cyc(1, 4'd7, 0, 0, 0, 16'h0, "halt_reset");
    cyc(0, 4'd7, 0, 0, 0, 16'h0, "halt_start");
    cyc(0, 4'd7, 0, 0, 0, FETCH, "halt_refetch");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
